// File: rtl/carus_launch_ctrl.sv
// rtl/carus_launch_ctrl.sv - NM-Carus launch sequencer: accept request, boot, watch run, report completion.
// Define CARUS_LAUNCH_STATS_EN to build the launch/timeout statistics counters.
module carus_launch_ctrl #(
  parameter int CNT_W  = 32,
  parameter int STAT_W = 16
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [31:0]       req_boot_pc_i,
  input  logic [CNT_W-1:0]  req_timeout_i,
  input  logic              abort_i,
  output logic [31:0]       carus_boot_pc_o,
  output logic              carus_fetch_en_o,
  output logic              carus_start_o,
  input  logic              carus_done_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [CNT_W-1:0]  rsp_cycles_o,
  output logic [1:0]        rsp_status_o,
  output logic              busy_o,
  output logic [STAT_W-1:0] launch_cnt_o,
  output logic [STAT_W-1:0] timeout_cnt_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CFG   = 3'd1,
    S_FETCH = 3'd2,
    S_RUN   = 3'd3,
    S_RESP  = 3'd4
  } state_t;

  localparam logic [1:0] ST_OK      = 2'd0;
  localparam logic [1:0] ST_TIMEOUT = 2'd1;
  localparam logic [1:0] ST_ABORT   = 2'd2;

  state_t           state_q;
  logic [31:0]      boot_pc_q;
  logic [CNT_W-1:0] timeout_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] rsp_cycles_q;
  logic [1:0]       rsp_status_q;
  logic             req_ready_q;
  logic             busy_q;
  logic             fetch_en_q;
  logic             start_q;
  logic             rsp_valid_q;

  logic             accept;
  logic             timeout_hit;
  logic             fin;
  logic [1:0]       fin_status;
  logic [CNT_W-1:0] fin_cycles;

  assign accept      = (state_q == S_IDLE) && req_valid_i;
  assign cnt_d       = (&cnt_q) ? cnt_q : cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
  assign timeout_hit = (timeout_q != '0) && (cnt_d == timeout_q);

  // Completion decode; the RUN cycle that completes still counts.
  always_comb begin
    fin        = 1'b0;
    fin_status = ST_OK;
    fin_cycles = cnt_q;
    case (state_q)
      S_CFG, S_FETCH: begin
        if (abort_i) begin
          fin        = 1'b1;
          fin_status = ST_ABORT;
        end
      end
      S_RUN: begin
        fin_cycles = cnt_d;
        if (abort_i) begin
          fin        = 1'b1;
          fin_status = ST_ABORT;
        end else if (carus_done_i) begin
          fin        = 1'b1;
          fin_status = ST_OK;
        end else if (timeout_hit) begin
          fin        = 1'b1;
          fin_status = ST_TIMEOUT;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q      <= S_IDLE;
      boot_pc_q    <= '0;
      timeout_q    <= '0;
      cnt_q        <= '0;
      rsp_cycles_q <= '0;
      rsp_status_q <= ST_OK;
      req_ready_q  <= 1'b1;
      busy_q       <= 1'b0;
      fetch_en_q   <= 1'b0;
      start_q      <= 1'b0;
      rsp_valid_q  <= 1'b0;
    end else begin
      start_q <= 1'b0;
      if (fin) begin
        state_q      <= S_RESP;
        rsp_valid_q  <= 1'b1;
        rsp_status_q <= fin_status;
        rsp_cycles_q <= fin_cycles;
        fetch_en_q   <= 1'b0;
      end
      case (state_q)
        S_IDLE: begin
          if (req_valid_i) begin
            state_q     <= S_CFG;
            boot_pc_q   <= req_boot_pc_i;
            timeout_q   <= req_timeout_i;
            cnt_q       <= '0;
            req_ready_q <= 1'b0;
            busy_q      <= 1'b1;
          end
        end
        S_CFG: begin
          if (!fin) begin
            state_q    <= S_FETCH;
            start_q    <= 1'b1;
            fetch_en_q <= 1'b1;
            cnt_q      <= '0;
          end
        end
        S_FETCH: begin
          if (!fin) state_q <= S_RUN;
        end
        S_RUN: begin
          cnt_q <= cnt_d;
        end
        S_RESP: begin
          if (rsp_ready_i) begin
            state_q     <= S_IDLE;
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ready_o      = req_ready_q;
  assign carus_boot_pc_o  = boot_pc_q;
  assign carus_fetch_en_o = fetch_en_q;
  assign carus_start_o    = start_q;
  assign rsp_valid_o      = rsp_valid_q;
  assign rsp_cycles_o     = rsp_cycles_q;
  assign rsp_status_o     = rsp_status_q;
  assign busy_o           = busy_q;

`ifdef CARUS_LAUNCH_STATS_EN
  logic [STAT_W-1:0] launch_cnt_q;
  logic [STAT_W-1:0] timeout_cnt_q;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      launch_cnt_q  <= '0;
      timeout_cnt_q <= '0;
    end else begin
      if (accept && !(&launch_cnt_q))
        launch_cnt_q <= launch_cnt_q + {{(STAT_W-1){1'b0}}, 1'b1};
      if (fin && (fin_status == ST_TIMEOUT) && !(&timeout_cnt_q))
        timeout_cnt_q <= timeout_cnt_q + {{(STAT_W-1){1'b0}}, 1'b1};
    end
  end

  assign launch_cnt_o  = launch_cnt_q;
  assign timeout_cnt_o = timeout_cnt_q;
`else
  logic unused_accept;
  assign unused_accept = accept;
  assign launch_cnt_o  = '0;
  assign timeout_cnt_o = '0;
`endif

endmodule
